// File: rtl/cvxif_copro_pkg.sv
// cvxif_copro_pkg: shared types and constants for the CV-X-IF coprocessor responder.
// Holds the custom-0 opcode, the funct3 operation enum, the pending-entry and
// result structs, and the responder FSM state enum.
package cvxif_copro_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRANS_ID_BITS = 4;
    localparam logic [6:0]  CUS_OPCODE    = 7'b0001011;

    typedef enum logic [2:0] {
        CUS_ADD       = 3'b000,
        CUS_ADD_MULTI = 3'b001,
        CUS_EXC       = 3'b010,
        CUS_NOP       = 3'b011
    } cus_op_e;

    typedef struct packed {
        cus_op_e                  op;
        logic [4:0]               rd;
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic [TRANS_ID_BITS-1:0] id;
        logic                     killed;
    } cus_req_t;

    typedef struct packed {
        logic                     valid;
        logic [TRANS_ID_BITS-1:0] id;
        logic [XLEN-1:0]          data;
        logic [4:0]               rd;
        logic                     we;
        logic                     exc;
        logic [5:0]               exccode;
    } cus_res_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/cvxif_copro_fifo.sv
// cvxif_copro_fifo: pending-request FIFO with a per-entry killed flag.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   push_i/push_data_i  enqueue (ignored when full)
//   pop_i/pop_data_o    dequeue / head entry (killed includes a same-cycle kill)
//   empty_o, full_o     occupancy flags
//   kill_valid_i/kill_id_i  mark every stored entry with a matching id as killed
module cvxif_copro_fifo
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  cus_req_t                 push_data_i,
    input  logic                     pop_i,
    output cus_req_t                 pop_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    input  logic                     kill_valid_i,
    input  logic [TRANS_ID_BITS-1:0] kill_id_i
);

    localparam int unsigned AW = $clog2(DEPTH);

    cus_req_t      mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // A kill landing in the same cycle the head leaves still counts for it.
    always_comb begin
        pop_data_o        = mem_q[rptr_q];
        pop_data_o.killed = mem_q[rptr_q].killed || (kill_valid_i && mem_q[rptr_q].id == kill_id_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // The push is written after the kill sweep so a new entry sharing the
    // killed id arrives clean.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(DEPTH); i++)
            if (kill_valid_i && mem_q[i].id == kill_id_i) mem_q[i].killed <= 1'b1;
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cvxif_copro_responder.sv
// cvxif_copro_responder: coprocessor side of the CV-X-IF offload path.
// Decodes custom-0 instructions, queues accepted work, executes in order and
// returns tagged results. CUS_EXC exists only when CVXIF_COPRO_EXC_EN is defined.
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   x_issue_*                            issue handshake, operands, accept/writeback
//   x_kill_valid_i, x_kill_id_i          kill by transaction id
//   x_result_*                           result channel (valid/ready, id, data, rd, we, exc)
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned PENDING_DEPTH = 4,
    parameter int unsigned MULTI_LATENCY = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     x_issue_valid_i,
    output logic                     x_issue_ready_o,
    input  logic [31:0]              x_issue_instr_i,
    input  logic [XLEN-1:0]          x_issue_rs1_i,
    input  logic [XLEN-1:0]          x_issue_rs2_i,
    input  logic [TRANS_ID_BITS-1:0] x_issue_id_i,
    output logic                     x_issue_accept_o,
    output logic                     x_issue_writeback_o,
    input  logic                     x_kill_valid_i,
    input  logic [TRANS_ID_BITS-1:0] x_kill_id_i,
    output logic                     x_result_valid_o,
    input  logic                     x_result_ready_i,
    output logic [TRANS_ID_BITS-1:0] x_result_id_o,
    output logic [XLEN-1:0]          x_result_data_o,
    output logic [4:0]               x_result_rd_o,
    output logic                     x_result_we_o,
    output logic                     x_result_exc_o,
    output logic [5:0]               x_result_exccode_o
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    cus_req_t   cur_q, cur_d, head, push_data;
    cus_res_t   res_q, res_d;
    logic [2:0] funct3;
    logic       dec_ok, push, pop, fifo_empty, fifo_full;
    logic       unused_instr;

    assign funct3       = x_issue_instr_i[14:12];
    assign unused_instr = ^x_issue_instr_i[31:15];

`ifdef CVXIF_COPRO_EXC_EN
    assign dec_ok = x_issue_instr_i[6:0] == CUS_OPCODE && !funct3[2];
`else
    assign dec_ok = x_issue_instr_i[6:0] == CUS_OPCODE && !funct3[2] && funct3 != CUS_EXC;
`endif

    assign x_issue_ready_o     = !rst_i && !fifo_full;
    assign x_issue_accept_o    = !rst_i && dec_ok;
    assign x_issue_writeback_o = x_issue_accept_o && funct3 != CUS_NOP;
    assign push                = x_issue_valid_i && x_issue_ready_o && dec_ok;

    always_comb begin
        push_data        = '0;
        push_data.op     = cus_op_e'(funct3);
        push_data.rd     = x_issue_instr_i[11:7];
        push_data.rs1    = x_issue_rs1_i;
        push_data.rs2    = x_issue_rs2_i;
        push_data.id     = x_issue_id_i;
    end

    cvxif_copro_fifo #(
        .DEPTH(PENDING_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .pop_data_o   (head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .kill_valid_i (x_kill_valid_i),
        .kill_id_i    (x_kill_id_i)
    );

    function automatic cus_res_t mk_res(cus_req_t r);
        cus_res_t s;
        s       = '0;
        s.valid = 1'b1;
        s.id    = r.id;
        s.rd    = r.rd;
`ifdef CVXIF_COPRO_EXC_EN
        s.exc   = r.op == CUS_EXC;
`else
        s.exc   = 1'b0;
`endif
        s.we      = !s.exc;
        s.data    = s.exc ? '0 : r.rs1 + r.rs2;
        s.exccode = s.exc ? r.rs2[5:0] : 6'd0;
        return s;
    endfunction

    // The pop cycle is the first execute cycle, so single-cycle ops go straight
    // to RESP and a result appears L cycles after the entry becomes visible.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    cur_d = head;
                    if (head.op != CUS_NOP && !head.killed) begin
                        if (head.op == CUS_ADD_MULTI && MULTI_LATENCY > 1) begin
                            cnt_d   = 4'(MULTI_LATENCY - 2);
                            state_d = ST_EXEC;
                        end else begin
                            state_d = ST_RESP;
                        end
                    end
                end
            end
            ST_EXEC: begin
                cur_d.killed = cur_q.killed || (x_kill_valid_i && x_kill_id_i == cur_q.id);
                cnt_d        = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = cur_d.killed ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (x_result_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        res_d = state_d != ST_RESP ? '0 : state_q == ST_RESP ? res_q : mk_res(cur_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            res_q   <= res_d;
        end
    end

    assign x_result_valid_o   = res_q.valid;
    assign x_result_id_o      = res_q.id;
    assign x_result_data_o    = res_q.data;
    assign x_result_rd_o      = res_q.rd;
    assign x_result_we_o      = res_q.we;
    assign x_result_exc_o     = res_q.exc;
    assign x_result_exccode_o = res_q.exccode;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// tb_cvxif_copro_responder: scoreboard bench for cvxif_copro_responder.
module tb_cvxif_copro_responder;

    localparam logic [6:0] C0   = 7'b0001011;
    localparam logic [6:0] LOAD = 7'b0000011;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        x_issue_valid_i = 1'b0;
    logic        x_issue_ready_o;
    logic [31:0] x_issue_instr_i = '0;
    logic [31:0] x_issue_rs1_i = '0;
    logic [31:0] x_issue_rs2_i = '0;
    logic [3:0]  x_issue_id_i = '0;
    logic        x_issue_accept_o;
    logic        x_issue_writeback_o;
    logic        x_kill_valid_i = 1'b0;
    logic [3:0]  x_kill_id_i = '0;
    logic        x_result_valid_o;
    logic        x_result_ready_i = 1'b1;
    logic [3:0]  x_result_id_o;
    logic [31:0] x_result_data_o;
    logic [4:0]  x_result_rd_o;
    logic        x_result_we_o;
    logic        x_result_exc_o;
    logic [5:0]  x_result_exccode_o;

    cvxif_copro_responder dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .x_issue_valid_i     (x_issue_valid_i),
        .x_issue_ready_o     (x_issue_ready_o),
        .x_issue_instr_i     (x_issue_instr_i),
        .x_issue_rs1_i       (x_issue_rs1_i),
        .x_issue_rs2_i       (x_issue_rs2_i),
        .x_issue_id_i        (x_issue_id_i),
        .x_issue_accept_o    (x_issue_accept_o),
        .x_issue_writeback_o (x_issue_writeback_o),
        .x_kill_valid_i      (x_kill_valid_i),
        .x_kill_id_i         (x_kill_id_i),
        .x_result_valid_o    (x_result_valid_o),
        .x_result_ready_i    (x_result_ready_i),
        .x_result_id_o       (x_result_id_o),
        .x_result_data_o     (x_result_data_o),
        .x_result_rd_o       (x_result_rd_o),
        .x_result_we_o       (x_result_we_o),
        .x_result_exc_o      (x_result_exc_o),
        .x_result_exccode_o  (x_result_exccode_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [48:0] exp_q[$];
    logic [48:0] last_res;
    logic        stall_seen = 1'b0;
    logic [48:0] act_res;

    assign act_res = {x_result_id_o, x_result_data_o, x_result_rd_o,
                      x_result_we_o, x_result_exc_o, x_result_exccode_o};

    function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        return {7'd0, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    function automatic logic [48:0] mk_res(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd,
                                           input logic we, input logic exc, input logic [5:0] code);
        return {id, d, rd, we, exc, code};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tid,
                         input logic exp_acc, input logic exp_wb, input logic push_exp, input logic [48:0] er);
        int n = 0;
        x_issue_valid_i = 1'b1;
        x_issue_instr_i = ins;
        x_issue_rs1_i   = a;
        x_issue_rs2_i   = b;
        x_issue_id_i    = tid;
        @(negedge clk_i);
        while (!x_issue_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!x_issue_ready_o) begin
            checks++;
            errors++;
            $display("FAIL issue_ready_timeout: got 0 expected 1");
        end
        chk("accept", 64'(x_issue_accept_o), 64'(exp_acc));
        chk("writeback", 64'(x_issue_writeback_o), 64'(exp_wb));
        if (push_exp) exp_q.push_back(er);
        @(posedge clk_i);
        #1;
        x_issue_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        step(2);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk_i) begin
        if (rst_i || !x_result_valid_o) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) chk("stable_while_stalled", 64'(act_res), 64'(last_res));
            if (x_result_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", act_res);
                end else begin
                    chk("result", 64'(act_res), 64'(exp_q.pop_front()));
                end
                stall_seen = 1'b0;
            end else begin
                last_res   = act_res;
                stall_seen = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        x_issue_instr_i = mk_instr(C0, 3'b000, 5'd1);
        @(negedge clk_i);
        chk("rst_ready", 64'(x_issue_ready_o), 64'd0);
        chk("rst_accept", 64'(x_issue_accept_o), 64'd0);
        chk("rst_valid", 64'(x_result_valid_o), 64'd0);
        chk("rst_data", 64'(x_result_data_o), 64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_rst", 64'(x_issue_ready_o), 64'd1);
        step(1);

        issue(mk_instr(C0, 3'b000, 5'd5), 32'd3, 32'd4, 4'd2, 1, 1, 1, mk_res(4'd2, 32'd7, 5'd5, 1, 0, 6'd0));
        @(negedge clk_i);
        chk("add_latency_n1", 64'(x_result_valid_o), 64'd0);
        @(negedge clk_i);
        chk("add_latency_n2", 64'(x_result_valid_o), 64'd1);
        step(2);

        issue(mk_instr(LOAD, 3'b010, 5'd6), 32'd9, 32'd9, 4'd3, 0, 0, 0, '0);
        issue(mk_instr(C0, 3'b100, 5'd6), 32'd9, 32'd9, 4'd3, 0, 0, 0, '0);
        issue(mk_instr(C0, 3'b011, 5'd6), 32'd9, 32'd9, 4'd4, 1, 0, 0, '0);
        step(6);
        @(negedge clk_i);
        chk("ready_after_rejects", 64'(x_issue_ready_o), 64'd1);
        step(1);

        x_result_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++)
            issue(mk_instr(C0, 3'b000, 5'(i + 10)), 32'(i * 100), 32'(i), 4'(i), 1, 1, 1,
                  mk_res(4'(i), 32'(i * 101), 5'(i + 10), 1, 0, 6'd0));
        @(negedge clk_i);
        chk("full_ready_low", 64'(x_issue_ready_o), 64'd0);
        step(3);
        @(negedge clk_i);
        chk("full_ready_hold", 64'(x_issue_ready_o), 64'd0);
        step(1);
        x_result_ready_i = 1'b1;
        drain();

        issue(mk_instr(C0, 3'b001, 5'd9), 32'd5, 32'd6, 4'd9, 1, 1, 1, mk_res(4'd9, 32'd11, 5'd9, 1, 0, 6'd0));
        @(negedge clk_i);
        chk("multi_latency_n1", 64'(x_result_valid_o), 64'd0);
        @(negedge clk_i);
        chk("multi_latency_n2", 64'(x_result_valid_o), 64'd0);
        @(negedge clk_i);
        chk("multi_latency_n3", 64'(x_result_valid_o), 64'd0);
        @(negedge clk_i);
        chk("multi_latency_n4", 64'(x_result_valid_o), 64'd1);
        step(1);
        drain();

        issue(mk_instr(C0, 3'b001, 5'd7), 32'd10, 32'd20, 4'd7, 1, 1, 0, '0);
        x_kill_valid_i = 1'b1;
        x_kill_id_i    = 4'd7;
        step(1);
        x_kill_valid_i = 1'b0;
        issue(mk_instr(C0, 3'b000, 5'd8), 32'd1, 32'd1, 4'd8, 1, 1, 1, mk_res(4'd8, 32'd2, 5'd8, 1, 0, 6'd0));
        drain();

        issue(mk_instr(C0, 3'b001, 5'd3), 32'd1, 32'd2, 4'd10, 1, 1, 0, '0);
        step(1);
        x_kill_valid_i = 1'b1;
        x_kill_id_i    = 4'd10;
        step(1);
        x_kill_valid_i = 1'b0;
        issue(mk_instr(C0, 3'b000, 5'd4), 32'd40, 32'd2, 4'd11, 1, 1, 1, mk_res(4'd11, 32'd42, 5'd4, 1, 0, 6'd0));
        drain();

        issue(mk_instr(C0, 3'b000, 5'd20), 32'hFFFF_FFFF, 32'd3, 4'd12, 1, 1, 1,
              mk_res(4'd12, 32'd2, 5'd20, 1, 0, 6'd0));
        x_kill_valid_i = 1'b1;
        x_kill_id_i    = 4'd13;
        step(1);
        x_kill_valid_i = 1'b0;
        drain();

`ifdef CVXIF_COPRO_EXC_EN
        issue(mk_instr(C0, 3'b010, 5'd12), 32'd99, 32'h2, 4'd5, 1, 1, 1, mk_res(4'd5, 32'd0, 5'd12, 0, 1, 6'd2));
`else
        issue(mk_instr(C0, 3'b010, 5'd12), 32'd99, 32'h2, 4'd5, 0, 0, 0, '0);
`endif
        drain();

        issue(mk_instr(C0, 3'b001, 5'd13), 32'd1, 32'd1, 4'd6, 1, 1, 0, '0);
        step(1);
        rst_i = 1'b1;
        #1;
        chk("rst_exec_ready", 64'(x_issue_ready_o), 64'd0);
        chk("rst_exec_valid", 64'(x_result_valid_o), 64'd0);
        step(2);
        rst_i = 1'b0;
        step(10);

        x_result_ready_i = 1'b0;
        issue(mk_instr(C0, 3'b000, 5'd2), 32'd8, 32'd8, 4'd1, 1, 1, 0, '0);
        step(1);
        chk("pre_rst_resp_valid", 64'(x_result_valid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("rst_resp_valid", 64'(x_result_valid_o), 64'd0);
        chk("rst_resp_data", 64'(x_result_data_o), 64'd0);
        chk("rst_resp_id", 64'(x_result_id_o), 64'd0);
        step(2);
        rst_i = 1'b0;
        x_result_ready_i = 1'b1;
        step(10);
        @(negedge clk_i);
        chk("ready_after_rst2", 64'(x_issue_ready_o), 64'd1);
        step(1);

        issue(mk_instr(C0, 3'b000, 5'd14), 32'd100, 32'd23, 4'd14, 1, 1, 1, mk_res(4'd14, 32'd123, 5'd14, 1, 0, 6'd0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
